// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, the per-axis phase enumeration and the count type.
package vga_timing_pkg;

    localparam int COUNT_W         = 10;
    localparam int COUNT_MAX_TOTAL = 1 << COUNT_W;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    typedef logic [COUNT_W-1:0] count_t;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter plus its ACTIVE/FRONT/SYNC/BACK phase FSM.
// Reset parks the axis on its last position so the first step lands on 0 / ACTIVE.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE_LEN = DEF_H_ACTIVE,
    parameter int FRONT_LEN  = DEF_H_FRONT,
    parameter int SYNC_LEN   = DEF_H_SYNC,
    parameter int BACK_LEN   = DEF_H_BACK
) (
    input  logic   clk_in,
    input  logic   rst_n,
    input  logic   step,
    output count_t count,
    output phase_t phase,
    output phase_t phase_nxt,
    output logic   wrap
);

    localparam int     TOTAL    = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;
    localparam count_t LAST     = count_t'(TOTAL - 1);
    localparam count_t FRONT_AT = count_t'(ACTIVE_LEN);
    localparam count_t SYNC_AT  = count_t'(ACTIVE_LEN + FRONT_LEN);
    localparam count_t BACK_AT  = count_t'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN);

    if (TOTAL > COUNT_MAX_TOTAL) begin : g_total_too_big
        $error("vga_axis_counter: axis total exceeds the 10-bit counter range");
    end

    count_t count_q, count_d;
    phase_t phase_q, phase_d;

    assign wrap = step && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (step) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    // Phase changes are keyed on the position being entered, so phase and count stay aligned.
    always_comb begin
        phase_d = phase_q;
        if (step) begin
            case (phase_q)
                PH_ACTIVE: if (count_d == FRONT_AT) phase_d = PH_FRONT;
                PH_FRONT:  if (count_d == SYNC_AT)  phase_d = PH_SYNC;
                PH_SYNC:   if (count_d == BACK_AT)  phase_d = PH_BACK;
                PH_BACK:   if (count_d == '0)       phase_d = PH_ACTIVE;
                default:   phase_d = PH_BACK;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= LAST;
            phase_q <= PH_BACK;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign count     = count_q;
    assign phase     = phase_q;
    assign phase_nxt = phase_d;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/position generator: two axis counters plus registered sync, blanking and start flags.
// Valid/ready does not apply here; en is a plain step strobe and every output holds while en=0.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_start,
    output logic       frame_start
);

    count_t h_count, v_count;
    phase_t h_phase, v_phase, h_phase_nxt, v_phase_nxt;
    logic   h_wrap, v_wrap, v_step;

    assign v_step = en && h_wrap;

    vga_axis_counter #(
        .ACTIVE_LEN(H_ACTIVE), .FRONT_LEN(H_FRONT), .SYNC_LEN(H_SYNC), .BACK_LEN(H_BACK)
    ) u_h_axis (
        .clk_in(clk_in), .rst_n(rst_n), .step(en),
        .count(h_count), .phase(h_phase), .phase_nxt(h_phase_nxt), .wrap(h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE_LEN(V_ACTIVE), .FRONT_LEN(V_FRONT), .SYNC_LEN(V_SYNC), .BACK_LEN(V_BACK)
    ) u_v_axis (
        .clk_in(clk_in), .rst_n(rst_n), .step(v_step),
        .count(v_count), .phase(v_phase), .phase_nxt(v_phase_nxt), .wrap(v_wrap)
    );

    // A wrap on this step means the next position has x=0 (and y=0 when the V axis also wraps).
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            hsync       <= (h_phase_nxt != PH_SYNC);
            vsync       <= (v_phase_nxt != PH_SYNC);
            video_on    <= (h_phase_nxt == PH_ACTIVE) && (v_phase_nxt == PH_ACTIVE);
            line_start  <= h_wrap;
            frame_start <= v_wrap;
        end
    end

    assign pixel_x = h_count;
    assign pixel_y = v_count;

    // The registered flags must always agree with the registered phases.
    always_ff @(posedge clk_in) begin
        if (rst_n) begin
            assert ((hsync == (h_phase != PH_SYNC)) && (vsync == (v_phase != PH_SYNC)) &&
                    (video_on == ((h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE))));
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance and a shrunken-timing instance for frame-level runs.
module tb_vga_timing_gen;

    localparam int S_HA = 20, S_HF = 3, S_HS = 4, S_HB = 5;
    localparam int S_VA = 6,  S_VF = 2, S_VS = 2, S_VB = 3;

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       video_on;
        logic       line_start;
        logic       frame_start;
        logic [9:0] x;
        logic [9:0] y;
    } obs_t;

    typedef struct {
        logic en;
        int   n;
        obs_t exp;
    } vec_t;

    // clock / reset
    logic clk_in = 1'b0;
    logic rst_n  = 1'b1;
    logic en     = 1'b0;
    always #5 clk_in = ~clk_in;

    logic       d_hsync, d_vsync, d_video_on, d_line_start, d_frame_start;
    logic [9:0] d_pixel_x, d_pixel_y;
    logic       s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start;
    logic [9:0] s_pixel_x, s_pixel_y;

    vga_timing_gen dut (
        .clk_in(clk_in), .rst_n(rst_n), .en(en),
        .hsync(d_hsync), .vsync(d_vsync), .video_on(d_video_on),
        .pixel_x(d_pixel_x), .pixel_y(d_pixel_y),
        .line_start(d_line_start), .frame_start(d_frame_start)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
    ) dut_small (
        .clk_in(clk_in), .rst_n(rst_n), .en(en),
        .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video_on),
        .pixel_x(s_pixel_x), .pixel_y(s_pixel_y),
        .line_start(s_line_start), .frame_start(s_frame_start)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: position per instance, outputs from the timing rules
    int t_ha[2] = '{640, S_HA};
    int t_hf[2] = '{16,  S_HF};
    int t_hs[2] = '{96,  S_HS};
    int t_hb[2] = '{48,  S_HB};
    int t_va[2] = '{480, S_VA};
    int t_vf[2] = '{10,  S_VF};
    int t_vs[2] = '{2,   S_VS};
    int t_vb[2] = '{33,  S_VB};
    int mx[2];
    int my[2];
    int s_max_y = 0;

    function automatic int h_tot(int k);
        return t_ha[k] + t_hf[k] + t_hs[k] + t_hb[k];
    endfunction

    function automatic int v_tot(int k);
        return t_va[k] + t_vf[k] + t_vs[k] + t_vb[k];
    endfunction

    function automatic obs_t model_obs(int k);
        obs_t o;
        int   x = mx[k];
        int   y = my[k];
        o.hsync       = !(x >= t_ha[k] + t_hf[k] && x < t_ha[k] + t_hf[k] + t_hs[k]);
        o.vsync       = !(y >= t_va[k] + t_vf[k] && y < t_va[k] + t_vf[k] + t_vs[k]);
        o.video_on    = (x < t_ha[k]) && (y < t_va[k]);
        o.line_start  = (x == 0);
        o.frame_start = (x == 0) && (y == 0);
        o.x           = 10'(x);
        o.y           = 10'(y);
        return o;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mx[k] = h_tot(k) - 1;
            my[k] = v_tot(k) - 1;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            mx[k] = mx[k] + 1;
            if (mx[k] == h_tot(k)) begin
                mx[k] = 0;
                my[k] = (my[k] + 1) % v_tot(k);
            end
        end
    endtask

    function automatic obs_t get_obs(int k);
        obs_t o;
        if (k == 0)
            o = '{d_hsync, d_vsync, d_video_on, d_line_start, d_frame_start, d_pixel_x, d_pixel_y};
        else
            o = '{s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start, s_pixel_x, s_pixel_y};
        return o;
    endfunction

    // scoreboard
    task automatic check(input string name, input obs_t got, input obs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got hs=%b vs=%b vid=%b ls=%b fs=%b (%0d,%0d) expected hs=%b vs=%b vid=%b ls=%b fs=%b (%0d,%0d)",
                     name, got.hsync, got.vsync, got.video_on, got.line_start, got.frame_start, got.x, got.y,
                     exp.hsync, exp.vsync, exp.video_on, exp.line_start, exp.frame_start, exp.x, exp.y);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_models();
        check("model_dut", get_obs(0), model_obs(0));
        check("model_small", get_obs(1), model_obs(1));
        if (int'(s_pixel_y) > s_max_y) s_max_y = int'(s_pixel_y);
    endtask

    // driver: call at a negedge; drives en, steps the model at the posedge, checks at the next negedge
    task automatic tick(input logic e);
        en = e;
        @(posedge clk_in);
        if (!rst_n) model_reset();
        else if (e) model_step();
        @(negedge clk_in);
        check_models();
    endtask

    function automatic vec_t mk(input logic e, input int n, input logic hs, input logic vs,
                                input logic vid, input logic ls, input logic fs, input int x, input int y);
        vec_t v;
        v.en  = e;
        v.n   = n;
        v.exp = '{hs, vs, vid, ls, fs, 10'(x), 10'(y)};
        return v;
    endfunction

    vec_t vecs[11];

    initial begin
        obs_t o;
        obs_t e;
        int   hs_low, first_x, hs_falls, ls_cnt, vid_cnt, fs_cnt, vs_low, bad_vs, guard;
        logic prev_hs;

        // default-timing walk from reset across the horizontal phase boundaries
        vecs[0]  = mk(1'b0, 1,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 799, 524);
        vecs[1]  = mk(1'b1, 1,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0,   0);
        vecs[2]  = mk(1'b1, 1,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1,   0);
        vecs[3]  = mk(1'b0, 3,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1,   0);
        vecs[4]  = mk(1'b1, 638, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 639, 0);
        vecs[5]  = mk(1'b1, 1,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 640, 0);
        vecs[6]  = mk(1'b1, 16,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 656, 0);
        vecs[7]  = mk(1'b1, 95,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 751, 0);
        vecs[8]  = mk(1'b1, 1,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 752, 0);
        vecs[9]  = mk(1'b1, 47,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 799, 0);
        vecs[10] = mk(1'b1, 1,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0,   1);

        #2 rst_n = 1'b0;
        model_reset();
        #1 check_models();
        @(negedge clk_in);
        for (int i = 0; i < 3; i++) tick(1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            for (int j = 0; j < vecs[i].n; j++) tick(vecs[i].en);
            check($sformatf("vec[%0d]", i), get_obs(0), vecs[i].exp);
        end

        // one full line at en=1: hsync low run
        hs_low = 0; first_x = -1; hs_falls = 0; ls_cnt = 0; prev_hs = 1'b1;
        for (int i = 0; i < 800; i++) begin
            o = get_obs(0);
            if (!o.hsync) begin
                if (hs_low == 0) first_x = int'(o.x);
                hs_low++;
            end
            if (prev_hs && !o.hsync) hs_falls++;
            if (o.line_start) ls_cnt++;
            prev_hs = o.hsync;
            tick(1'b1);
        end
        check_int("hsync_low_cycles", hs_low, 96);
        check_int("hsync_first_x", first_x, 656);
        check_int("hsync_pulses", hs_falls, 1);
        check_int("line_start_per_line", ls_cnt, 1);
        check_int("line_period_x", int'(d_pixel_x), 0);
        check_int("line_period_ls", int'(d_line_start), 1);

        // en on every other clock: everything stretches to twice the clocks
        hs_low = 0; ls_cnt = 0;
        for (int i = 0; i < 1600; i++) begin
            o = get_obs(0);
            if (!o.hsync) hs_low++;
            if (o.line_start) ls_cnt++;
            tick(logic'(i % 2 == 1));
        end
        check_int("half_rate_hsync_clocks", hs_low, 192);
        check_int("half_rate_ls_clocks", ls_cnt, 2);
        check_int("half_rate_period_x", int'(d_pixel_x), 0);
        check_int("half_rate_period_y", int'(d_pixel_y), 3);

        // async reset in the middle of a small-instance hsync pulse, between clock edges
        guard = 0;
        while (mx[1] != 24 && guard < 100) begin
            tick(1'b1);
            guard++;
        end
        check_int("reach_mid_hsync", mx[1], 24);
        #3 rst_n = 1'b0;
        model_reset();
        #1 check_models();
        check_int("reset_ends_hsync", int'(s_hsync), 1);
        @(negedge clk_in);
        tick(1'b1);
        tick(1'b1);
        rst_n = 1'b1;
        tick(1'b1);
        e = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0};
        check("first_en_dut", get_obs(0), e);
        check("first_en_small", get_obs(1), e);

        // two full frames of the small timing
        vid_cnt = 0; fs_cnt = 0; vs_low = 0; bad_vs = 0;
        for (int i = 0; i < 2 * 32 * 13; i++) begin
            o = get_obs(1);
            if (o.video_on) vid_cnt++;
            if (o.frame_start) fs_cnt++;
            if (!o.vsync) begin
                vs_low++;
                if (o.y != 10'd8 && o.y != 10'd9) bad_vs++;
            end
            tick(1'b1);
        end
        check_int("frame_video_on", vid_cnt, 2 * S_HA * S_VA);
        check_int("frame_start_count", fs_cnt, 2);
        check_int("frame_vsync_low", vs_low, 2 * 2 * 32);
        check_int("frame_vsync_lines", bad_vs, 0);
        check_int("frame_period_fs", int'(s_frame_start), 1);

        // simultaneous H and V wrap
        guard = 0;
        while (!(mx[1] == 31 && my[1] == 12) && guard < 500) begin
            tick(1'b1);
            guard++;
        end
        check_int("pre_wrap_xy", int'({s_pixel_x, s_pixel_y}), (31 << 10) | 12);
        tick(1'b1);
        check("double_wrap", get_obs(1), e);

        // random en stream
        for (int i = 0; i < 2000; i++) tick(logic'($urandom_range(0, 3) != 0));

        check_int("small_max_y", s_max_y, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
